// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: writeback arbiter for the FP execution units (MAC, div/sqrt, convert).
// Each cycle it picks one pending unit result round-robin, acks it, and registers it
// into a single-entry output stage. That stage feeds the FP register-file write port
// and the ID-retire logic.
//
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   unit_done  per-unit result valid, held until acked
//   unit_rd    per-unit result, unit i at [i*DATA_W +: DATA_W]
//   unit_id    per-unit instruction ID, unit i at [i*ID_W +: ID_W]
//   unit_ack   one-hot (or zero) consume strobe
//   out_valid  registered writeback valid
//   out_data   registered result
//   out_id     registered instruction ID
//   out_ready  downstream accepts out_* this cycle
//
// Optional build macro FP_WB_PERF_CNT_EN adds two outputs:
//   grant_cnt  per-unit 32-bit grant counters
//   stall_cnt  cycles with a pending result but a blocked output stage
module fp_wb_arbiter #(
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned DATA_W    = 34,
   parameter int unsigned ID_W      = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_UNITS-1:0]        unit_done,
   input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
   input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
   output logic [NUM_UNITS-1:0]        unit_ack,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [ID_W-1:0]             out_id,
   input  logic                        out_ready
`ifdef FP_WB_PERF_CNT_EN
   ,
   output logic [NUM_UNITS*32-1:0]     grant_cnt,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [PtrW-1:0]   rr_ptr_q;
   logic [PtrW-1:0]   grant_idx;
   logic [PtrW-1:0]   ptr_nxt;
   logic              grant_valid;
   logic              accept;
   logic              ack_en;
   logic [DATA_W-1:0] sel_rd;
   logic [ID_W-1:0]   sel_id;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ID_W-1:0]   out_id_q;

   assign grant_valid = |unit_done;
   // The stage is free, or its current entry drains on this edge.
   assign accept      = !out_valid_q || out_ready;
   assign ack_en      = grant_valid && accept && rst;

   // Scan from rr_ptr upward, wrapping modulo NUM_UNITS. The first done unit wins.
   always_comb begin : grant_scan
      logic [PtrW:0]   sum;
      logic [PtrW-1:0] cand;
      logic            found;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         sum = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
         if (sum >= (PtrW+1)'(NUM_UNITS)) begin
            sum = sum - (PtrW+1)'(NUM_UNITS);
         end
         cand = sum[PtrW-1:0];
         if (!found && unit_done[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Select the winner's payload.
   always_comb begin
      sel_rd = '0;
      sel_id = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         if (grant_idx == PtrW'(k)) begin
            sel_rd = unit_rd[k*DATA_W +: DATA_W];
            sel_id = unit_id[k*ID_W +: ID_W];
         end
      end
   end

   always_comb begin
      unit_ack = '0;
      if (ack_en) begin
         unit_ack[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      if (NUM_UNITS == 1) begin
         ptr_nxt = '0;
      end else if (grant_idx == PtrW'(NUM_UNITS - 1)) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = grant_idx + PtrW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else if (ack_en) begin
         // A new entry loads while any old one drains, so there is no bubble.
         out_valid_q <= 1'b1;
         out_data_q  <= sel_rd;
         out_id_q    <= sel_id;
         rr_ptr_q    <= ptr_nxt;
      end else if (accept) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

`ifdef FP_WB_PERF_CNT_EN
   logic [31:0] grant_cnt_q [NUM_UNITS];
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            grant_cnt_q[i] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (unit_ack[i]) begin
               grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
         end
         if (grant_valid && !accept) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         grant_cnt[i*32 +: 32] = grant_cnt_q[i];
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed testbench for fp_wb_arbiter with the default parameters (3 units, 34-bit data, 3-bit ID).
module tb_fp_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  unit_done = '0;
   logic [33:0] rd_arr [3];
   logic [2:0]  id_arr [3];
   logic [101:0] unit_rd;
   logic [8:0]  unit_id;
   logic [2:0]  unit_ack;
   logic        out_valid;
   logic [33:0] out_data;
   logic [2:0]  out_id;
   logic        out_ready = 1'b1;
`ifdef FP_WB_PERF_CNT_EN
   logic [95:0] grant_cnt;
   logic [31:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int viol  = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         unit_rd[i*34 +: 34] = rd_arr[i];
         unit_id[i*3 +: 3]   = id_arr[i];
      end
   end

   fp_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .unit_done (unit_done),
      .unit_rd   (unit_rd),
      .unit_id   (unit_id),
      .unit_ack  (unit_ack),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready)
`ifdef FP_WB_PERF_CNT_EN
      ,
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   // A unit must not drop done unless it was acked in that cycle. Reset cycles are exempt.
   logic [2:0] last_done;
   logic [2:0] last_ack;
   logic       last_ok = 1'b0;
   always @(posedge clk) begin
      if (last_ok && rst) begin
         for (int i = 0; i < 3; i++) begin
            if (last_done[i] && !last_ack[i] && !unit_done[i]) viol <= viol + 1;
         end
      end
      last_done <= unit_done;
      last_ack  <= unit_ack;
      last_ok   <= 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      unit_done = '0;
      out_ready = 1'b1;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      unit_done = '0;
      out_ready = 1'b1;
      step();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 34'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
      total++; if (out_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", out_id); end
      total++; if (unit_ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b want=000", unit_ack); end
      rst = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      rd_arr[1] = 34'h0_3F80_0000;
      id_arr[1] = 3'd2;
      unit_done = 3'b010;
      #1;
      total++; if (unit_ack !== 3'b010) begin bad++; $display("FAIL single_ack got=%b want=010", unit_ack); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b want=0", out_valid); end
      step();
      unit_done = 3'b000;
      #1;
      total++; if (unit_ack !== 3'b000) begin bad++; $display("FAIL single_ack_idle got=%b want=000", unit_ack); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
      total++; if (out_data !== 34'h0_3F80_0000) begin bad++; $display("FAIL single_data got=%h want=03f800000", out_data); end
      total++; if (out_id !== 3'd2) begin bad++; $display("FAIL single_id got=%0d want=2", out_id); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_ack;
      int          u;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         id_arr[i] = 3'(i + 4);
         rd_arr[i] = 34'h1_0000_0000 | 34'(i + 16);
      end
      unit_done = 3'b111;
      for (int c = 0; c < 4; c++) begin
         u = c % 3;
         exp_ack = 3'b001 << u;
         #1;
         total++; if (unit_ack !== exp_ack) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", c, unit_ack, exp_ack); end
         step();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b want=1", c, out_valid); end
         total++; if (out_id !== 3'(u + 4)) begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", c, out_id, u + 4); end
         total++; if (out_data !== (34'h1_0000_0000 | 34'(u + 16))) begin bad++; $display("FAIL rr_data[%0d] got=%h want=%h", c, out_data, 34'h1_0000_0000 | 34'(u + 16)); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rd_arr[0] = 34'h2_AAAA_5555;
      id_arr[0] = 3'd3;
      unit_done = 3'b001;
      #1;
      total++; if (unit_ack !== 3'b001) begin bad++; $display("FAIL bp_first_ack got=%b want=001", unit_ack); end
      step();
      // Unit 0 presents its next result while the stage is blocked.
      out_ready = 1'b0;
      rd_arr[0] = 34'h1_1234_5678;
      id_arr[0] = 3'd7;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (unit_ack !== 3'b000) begin bad++; $display("FAIL bp_ack[%0d] got=%b want=000", c, unit_ack); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", c, out_valid); end
         total++; if (out_id !== 3'd3) begin bad++; $display("FAIL bp_id[%0d] got=%0d want=3", c, out_id); end
         total++; if (out_data !== 34'h2_AAAA_5555) begin bad++; $display("FAIL bp_data[%0d] got=%h want=2aaaa5555", c, out_data); end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (unit_ack !== 3'b001) begin bad++; $display("FAIL bp_release_ack got=%b want=001", unit_ack); end
      step();
      unit_done = 3'b000;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b want=1", out_valid); end
      total++; if (out_id !== 3'd7) begin bad++; $display("FAIL bp_next_id got=%0d want=7", out_id); end
      total++; if (out_data !== 34'h1_1234_5678) begin bad++; $display("FAIL bp_next_data got=%h want=112345678", out_data); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 3; i++) id_arr[i] = 3'(i + 1);
      unit_done = 3'b010;
      #1;
      total++; if (unit_ack !== 3'b010) begin bad++; $display("FAIL wrap_setup_ack got=%b want=010", unit_ack); end
      step();
      // Pointer is now 2: only unit 0 is done.
      unit_done = 3'b001;
      #1;
      total++; if (unit_ack !== 3'b001) begin bad++; $display("FAIL wrap_u0_ack got=%b want=001", unit_ack); end
      step();
      total++; if (out_id !== 3'd1) begin bad++; $display("FAIL wrap_u0_id got=%0d want=1", out_id); end
      // Pointer is now 1: only unit 2 is done.
      unit_done = 3'b100;
      #1;
      total++; if (unit_ack !== 3'b100) begin bad++; $display("FAIL wrap_u2_ack got=%b want=100", unit_ack); end
      step();
      total++; if (out_id !== 3'd3) begin bad++; $display("FAIL wrap_u2_id got=%0d want=3", out_id); end
      // Pointer wrapped to 0, so unit 0 beats unit 1.
      unit_done = 3'b011;
      #1;
      total++; if (unit_ack !== 3'b001) begin bad++; $display("FAIL wrap_ptr0_ack got=%b want=001", unit_ack); end
   endtask

   task automatic test_reset_midflow();
      do_reset();
      id_arr[1] = 3'd5;
      rd_arr[1] = 34'h0_4000_0000;
      unit_done = 3'b010;
      step();
      total++; if (out_id !== 3'd5 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_hold got=%b/%0d want=1/5", out_valid, out_id); end
      // Pointer is 2. Hold the entry and reset with units 0 and 2 pending.
      out_ready = 1'b0;
      unit_done = 3'b101;
      rst = 1'b0;
      #1;
      total++; if (unit_ack !== 3'b000) begin bad++; $display("FAIL mid_rst_ack got=%b want=000", unit_ack); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
      total++; if (out_id !== 3'd0) begin bad++; $display("FAIL mid_rst_id got=%0d want=0", out_id); end
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      total++; if (unit_ack !== 3'b001) begin bad++; $display("FAIL mid_first_ack got=%b want=001", unit_ack); end
   endtask

`ifdef FP_WB_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      unit_done = 3'b010;
      for (int c = 0; c < 10; c++) step();
      total++; if (grant_cnt[32 +: 32] !== 32'd10) begin bad++; $display("FAIL perf_grant1 got=%0d want=10", grant_cnt[32 +: 32]); end
      total++; if (grant_cnt[0 +: 32] !== 32'd0) begin bad++; $display("FAIL perf_grant0 got=%0d want=0", grant_cnt[0 +: 32]); end
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) step();
      total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d want=4", stall_cnt); end
      total++; if (grant_cnt[32 +: 32] !== 32'd10) begin bad++; $display("FAIL perf_grant_hold got=%0d want=10", grant_cnt[32 +: 32]); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 3; i++) begin
         rd_arr[i] = '0;
         id_arr[i] = '0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_midflow();
`ifdef FP_WB_PERF_CNT_EN
      test_perf();
`endif
      step();
      total++; if (viol !== 0) begin bad++; $display("FAIL protocol_done_drop got=%0d want=0", viol); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Consumer end of the unit writeback handshake (done/rd/id in, ack out) for the FP execution units, e.g. MAC, div/sqrt and convert.
- Arbitrates round-robin among NUM_UNITS pending results and grants at most one ack per cycle.
- Registers the winner into a single-entry output stage that feeds the FP register-file write port and the ID-retire logic.
- The output stage has its own valid/ready backpressure.

Parameters:
- NUM_UNITS, 3, number of writeback sources (1..8).
- DATA_W, 34, result width (flopoco format: 2 exception bits, sign, exponent, mantissa).
- ID_W, 3, instruction ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- unit_done  in  NUM_UNITS  per-unit result valid; held until acked.
- unit_rd  in  NUM_UNITS*DATA_W  per-unit result; unit i occupies slice [i*DATA_W +: DATA_W].
- unit_id  in  NUM_UNITS*ID_W  per-unit instruction ID; unit i occupies slice [i*ID_W +: ID_W].
- unit_ack  out  NUM_UNITS  one-hot (or zero) consume strobe; the result is taken in the cycle ack=1.
- out_valid  out  1  registered writeback valid.
- out_data  out  DATA_W  registered result.
- out_id  out  ID_W  registered ID.
- out_ready  in  1  downstream accepts out_* this cycle.

Behaviour:
- Reset: when rst==0 at posedge clk, out_valid<=0, rr_ptr<=0, out_data/out_id<=0, and all counters are cleared.
  - unit_ack is forced to 0 combinationally while rst==0.
  - A result in flight in the output stage is discarded.
  - Units keep done asserted and are served after reset releases.
- accept = !out_valid || out_ready (output stage is free or draining this cycle).
- Grant selection (combinational):
  - Scan units starting at rr_ptr, wrapping modulo NUM_UNITS; the first unit with unit_done=1 wins.
  - grant_valid = |unit_done.
- unit_ack[g] = grant_valid && accept && rst; all other ack bits are 0. unit_ack never has more than one bit set.
- On a posedge with ack issued:
  - out_valid<=1, out_data<=unit_rd slice g, out_id<=unit_id slice g.
  - rr_ptr <= (g+1) mod NUM_UNITS, wrapping from NUM_UNITS-1 to 0.
- On a posedge with accept=1 and no grant: out_valid<=0 and rr_ptr is unchanged.
- On a posedge with out_valid=1 and out_ready=0: out_* hold and no ack is issued.
- Latency: a result acked in cycle N appears on out_* in cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous out_ready=1 and a new grant: the old entry drains and the new one loads in the same edge, with no bubble.
- Fairness: with all units continuously done, each unit is granted exactly once every NUM_UNITS grants.
- unit_done dropping without an ack is a protocol violation.
  - The arbiter simply re-evaluates each cycle.
  - The bench asserts it never happens.
- NUM_UNITS==1 degenerates to a registered pass-through: rr_ptr is held at 0 and ack = done && accept.

Optional Feature:
- Macro: FP_WB_PERF_CNT_EN.
- Defined:
  - Adds output port grant_cnt (NUM_UNITS*32), one 32-bit counter per unit, incremented on each unit_ack[i].
  - Adds output port stall_cnt (32), incremented each cycle that grant_valid=1 && accept=0.
  - All counters wrap 2^32-1 -> 0 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-flow: out_valid=1 holding id=5, drive rst=0 for 1 cycle -> next cycle out_valid=0, unit_ack=0 during reset, rr_ptr=0. The first grant after reset goes to the lowest done unit.
- Single source: unit1 done, rd=34'h0_3F80_0000, id=2, out_ready=1 -> unit_ack=3'b010 in cycle N. In cycle N+1: out_valid=1, out_data=34'h0_3F80_0000, out_id=2.
- Round robin: units 0, 1 and 2 all done continuously, out_ready=1 -> acks 001, 010, 100, 001 on consecutive cycles; out_id follows unit order.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with unit0 done -> unit_ack=0 and out_* stable throughout. When out_ready=1, unit0 is acked that cycle and its result appears the next cycle with no bubble.
- Wrap: rr_ptr=2 and only unit0 done -> unit0 granted and rr_ptr becomes 1. Then only unit2 done -> unit2 granted and rr_ptr becomes 0.
- FP_WB_PERF_CNT_EN:
  - 10 grants to unit1 -> grant_cnt[1]=10.
  - 4 backpressure cycles with a pending done -> stall_cnt=4.
  - Preload a counter to 32'hFFFF_FFFF and grant once -> it wraps to 0.
